// File: rtl/temp_sample_scheduler.sv
`default_nettype none
// ============================================================================
// temp_sample_scheduler
//   Paces temperature sensor reads and averages 2^AVG_LOG2 samples into a
//   published mean. It also tracks the running min/max of published means and
//   supervises sensor health with a soft-reset retry sequence and a sticky
//   fault. The optional min/max tracker is enabled by TEMP_SCHED_MINMAX_EN.
//   Rev 1.0
// ============================================================================
module temp_sample_scheduler #(
  parameter int SAMPLE_DIV = 100000000,
  parameter int AVG_LOG2   = 2,
  parameter int ERR_RETRY  = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [12:0] temp_i,
  input  logic        rdy_i,
  input  logic        err_i,
  input  logic        hold_i,
  output logic        sensor_srst_o,
  output logic [12:0] temp_o,
  output logic [12:0] min_o,
  output logic [12:0] max_o,
  output logic        valid_o,
  output logic        fault_o
);

  localparam int TW     = 13;
  localparam int SUM_W  = TW + AVG_LOG2;
  localparam int TICK_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int SCNT_W = AVG_LOG2 + 1;
  localparam int RCNT_W = $clog2(ERR_RETRY + 2);

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(SAMPLE_DIV - 1);
  localparam logic [SCNT_W-1:0] SCNT_FULL = SCNT_W'(1 << AVG_LOG2);
  localparam logic [RCNT_W-1:0] RETRY_MAX = RCNT_W'(ERR_RETRY);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WAIT_RDY = 3'd1,
    PUBLISH  = 3'd2,
    RECOVER  = 3'd3,
    FAULT    = 3'd4
  } state_t;

  state_t                    state;
  logic [TICK_W-1:0]         tick_cnt;
  logic                      tick;
  logic signed [SUM_W-1:0]   sum;
  logic signed [SUM_W-1:0]   sample_ext;
  logic signed [TW-1:0]      mean;
  logic [SCNT_W-1:0]         sample_cnt;
  logic [RCNT_W-1:0]         retry_cnt;
  logic [1:0]                rec_cnt;

  assign tick       = (state != FAULT) && (tick_cnt == TICK_LAST);
  assign sample_ext = {{AVG_LOG2{temp_i[TW-1]}}, temp_i};
  assign mean       = TW'(sum >>> AVG_LOG2);

  // The sample clock freezes once the block has given up on the sensor.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tick_cnt <= '0;
    end else if (state != FAULT) begin
      tick_cnt <= (tick_cnt == TICK_LAST) ? '0 : tick_cnt + TICK_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      sum           <= '0;
      sample_cnt    <= '0;
      retry_cnt     <= '0;
      rec_cnt       <= '0;
      temp_o        <= '0;
      valid_o       <= 1'b0;
      sensor_srst_o <= 1'b0;
      fault_o       <= 1'b0;
    end else begin
      valid_o <= 1'b0;
      case (state)
        IDLE: begin
          if (tick) state <= WAIT_RDY;
        end
        WAIT_RDY: begin
          // A sensor error outranks a simultaneous data-ready.
          if (err_i || (tick && !rdy_i)) begin
            state         <= RECOVER;
            sensor_srst_o <= 1'b1;
            rec_cnt       <= '0;
            retry_cnt     <= retry_cnt + RCNT_W'(1);
            sum           <= '0;
            sample_cnt    <= '0;
          end else if (rdy_i) begin
            sum        <= sum + sample_ext;
            sample_cnt <= sample_cnt + SCNT_W'(1);
            retry_cnt  <= '0;
            state      <= ((sample_cnt + SCNT_W'(1)) == SCNT_FULL) ? PUBLISH : IDLE;
          end
        end
        PUBLISH: begin
          sum        <= '0;
          sample_cnt <= '0;
          if (!hold_i) begin
            temp_o  <= mean;
            valid_o <= 1'b1;
          end
          state <= IDLE;
        end
        RECOVER: begin
          if (rec_cnt == 2'd3) begin
            sensor_srst_o <= 1'b0;
            if (retry_cnt > RETRY_MAX) begin
              state   <= FAULT;
              fault_o <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end else begin
            rec_cnt <= rec_cnt + 2'd1;
          end
        end
        FAULT: begin
          sensor_srst_o <= 1'b0;
          fault_o       <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef TEMP_SCHED_MINMAX_EN
  logic seen;

  // The first published mean seeds both extremes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      min_o <= '0;
      max_o <= '0;
      seen  <= 1'b0;
    end else if (state == PUBLISH && !hold_i) begin
      seen <= 1'b1;
      if (!seen || (mean < signed'(min_o))) min_o <= mean;
      if (!seen || (mean > signed'(max_o))) max_o <= mean;
    end
  end
`else
  assign min_o = '0;
  assign max_o = '0;
`endif

endmodule
`default_nettype wire
